// File: rtl/mem_arbiter.sv
// Two-client round-robin arbiter and sequencer in front of a single negedge-clocked memory.
// Optional WAIT timeout with a sticky err output: define MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter #(
  parameter int WORD_SIZE    = 8,
  parameter int ADDRESS_SIZE = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    a_req,
  input  logic                    a_we,
  input  logic [ADDRESS_SIZE-1:0] a_addr,
  input  logic [WORD_SIZE-1:0]    a_wdata,
  output logic                    a_ack,
  output logic [WORD_SIZE-1:0]    a_rdata,
  input  logic                    b_req,
  input  logic                    b_we,
  input  logic [ADDRESS_SIZE-1:0] b_addr,
  input  logic [WORD_SIZE-1:0]    b_wdata,
  output logic                    b_ack,
  output logic [WORD_SIZE-1:0]    b_rdata,
  output logic                    mem_r_en,
  output logic                    mem_w_en,
  output logic [ADDRESS_SIZE-1:0] mem_r_addr,
  output logic [ADDRESS_SIZE-1:0] mem_w_addr,
  output logic [WORD_SIZE-1:0]    mem_w_data,
  input  logic [WORD_SIZE-1:0]    mem_r_data,
  input  logic                    mem_r_ready,
  input  logic                    mem_w_ready,
`ifdef MEM_ARBITER_TIMEOUT_EN
  output logic                    err,
`endif
  output logic                    busy
);

  typedef enum logic [2:0] {INIT, IDLE, ISSUE, WAIT, DONE} state_t;

  state_t state, state_nxt;
  logic   owner_b;       // 1 when client B owns the current transaction
  logic   last_grant_b;  // 1 when B received the most recent grant
  logic   cur_we;
  logic   grant, grant_b, capture, ready_sel;

  logic                    sel_we;
  logic [ADDRESS_SIZE-1:0] sel_addr;
  logic [WORD_SIZE-1:0]    sel_wdata;

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout;
`else
  // TIMEOUT only matters when the timeout logic is built in.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  assign sel_we    = grant_b ? b_we    : a_we;
  assign sel_addr  = grant_b ? b_addr  : a_addr;
  assign sel_wdata = grant_b ? b_wdata : a_wdata;
  assign ready_sel = cur_we ? mem_w_ready : mem_r_ready;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_nxt = state;
    grant     = 1'b0;
    grant_b   = 1'b0;
    capture   = 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
    timeout   = 1'b0;
`endif
    case (state)
      INIT:  if (mem_r_ready && mem_w_ready) state_nxt = IDLE;
      IDLE: begin
        if (a_req || b_req) begin
          grant     = 1'b1;
          // B wins only when alone or when A had the previous grant.
          grant_b   = b_req && (!a_req || !last_grant_b);
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (ready_sel) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
`ifdef MEM_ARBITER_TIMEOUT_EN
        else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          timeout   = 1'b1;
          state_nxt = DONE;
        end
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state        <= INIT;
      last_grant_b <= 1'b1;
      owner_b      <= 1'b0;
      cur_we       <= 1'b0;
      mem_r_addr   <= '0;
      mem_w_addr   <= '0;
      mem_w_data   <= '0;
      a_rdata      <= '0;
      b_rdata      <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner_b      <= grant_b;
        last_grant_b <= grant_b;
        cur_we       <= sel_we;
        if (sel_we) begin
          mem_w_addr <= sel_addr;
          mem_w_data <= sel_wdata;
        end else begin
          mem_r_addr <= sel_addr;
        end
      end
      if (capture && !cur_we) begin
        if (owner_b) b_rdata <= mem_r_data;
        else         a_rdata <= mem_r_data;
      end
    end
  end

`ifdef MEM_ARBITER_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (state == ISSUE)     wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
      if (timeout) err <= 1'b1;
    end
  end
`endif

  // Strobes and acks decode directly from state, so a reset edge drops them immediately.
  assign mem_w_en = (state == ISSUE) && cur_we;
  assign mem_r_en = (state == ISSUE) && !cur_we;
  assign a_ack    = (state == DONE) && !owner_b;
  assign b_ack    = (state == DONE) && owner_b;
  assign busy     = (state != IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of one memory instance (negedge-clocked, with r_en/w_en strobes and r_ready/w_ready status).
- Each client makes one read or write request at a time over a level req / one-cycle ack handshake.
- The arbiter serialises the requests, drives the memory ports, waits for the memory's ready, and returns read data.
- It also holds off all traffic until the memory's post-reset init sweep is complete.

Parameters:
- WORD_SIZE, 8, data width (must match the memory).
- ADDRESS_SIZE, 4, address width (must match the memory).
- TIMEOUT, 15, max WAIT cycles before error (used only with the optional feature).

Ports:
- clock  in  1  system clock. Arbiter logic is posedge.
- reset  in  1  synchronous, active-high; shared with the memory.
- a_req  in  1  client A request; held until a_ack.
- a_we  in  1  client A: 1=write, 0=read.
- a_addr  in  ADDRESS_SIZE  client A address.
- a_wdata  in  WORD_SIZE  client A write data.
- a_ack  out  1  one-cycle completion pulse to A.
- a_rdata  out  WORD_SIZE  read data to A; valid when a_ack=1, held after.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as the A ports, for client B.
- mem_r_en  out  1  memory read strobe.
- mem_w_en  out  1  memory write strobe.
- mem_r_addr  out  ADDRESS_SIZE  memory read address.
- mem_w_addr  out  ADDRESS_SIZE  memory write address.
- mem_w_data  out  WORD_SIZE  memory write data.
- mem_r_data  in  WORD_SIZE  memory read data.
- mem_r_ready  in  1  memory read-ready status.
- mem_w_ready  in  1  memory write-ready status.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- All state is registered on posedge clock.
- Reset (synchronous, active-high), values on the first posedge with reset=1:
  - state=INIT, last_grant=B (so A wins the first tie);
  - a_ack=b_ack=0, a_rdata=b_rdata=0;
  - mem_r_en=mem_w_en=0, mem address/data registers=0, busy=1.
- Reset mid-transaction: abort immediately, no ack, strobes drop on the same edge, return to INIT.
- States: INIT, IDLE, ISSUE, WAIT, DONE.
- INIT:
  - stay until mem_r_ready=1 and mem_w_ready=1 are sampled together, then go to IDLE.
  - client requests are ignored in INIT, not lost; req remains asserted.
- IDLE (busy=0):
  - neither req → stay.
  - one req → grant it.
  - both req → grant the client not equal to last_grant.
  - on grant: latch owner, we, addr and wdata into the mem_* address/data registers; update last_grant; go to ISSUE.
- ISSUE (exactly one cycle):
  - mem_w_en=1 if we, else mem_r_en=1; the other strobe stays 0.
  - go to WAIT.
- WAIT:
  - strobes=0.
  - sample mem_w_ready (write) or mem_r_ready (read) each posedge; on the first 1, capture mem_r_data into owner's rdata (reads only) and go to DONE.
  - the memory deasserts ready on the negedge inside the ISSUE cycle, so a stale ready is never seen.
- DONE (one cycle):
  - owner ack=1; go to IDLE.
  - client must deassert req on the posedge ending DONE; a req still high in IDLE is a new request.
- Latency: with memory wait=0, ack is asserted 3 cycles after the IDLE edge that grants (IDLE→ISSUE→WAIT→DONE). Each memory wait cycle adds one.
- Throughput: back-to-back requests alternate A/B with one IDLE cycle between transactions.
- A non-owner's req, we, addr and wdata are don't-care until it is granted. The non-owner's rdata is unchanged by the other client's transactions.
- The memory address/data registers hold their values outside ISSUE.
- At most one memory strobe is ever asserted, and only in ISSUE.
- Inputs a_req/b_req are assumed synchronous to clock; no synchronisers.

Optional Feature:
- Macro: MEM_ARBITER_TIMEOUT_EN.
- With the macro defined:
  - add output err (1 bit, reset 0) and a WAIT-cycle counter (reset 0, cleared on entry to WAIT).
  - if the counter reaches TIMEOUT without ready: set err=1 (sticky until reset), pulse the owner's ack with rdata unchanged, and go to IDLE.
- Without the macro: no err port, no counter; WAIT waits forever.

Test Plan:
- Reset then hold ready low 20 cycles with a_req=1 → no strobes, a_ack=0, busy=1; ready high → A granted, first mem_w_en/mem_r_en 2 cycles later.
- A writes 8'hA5 @4'h3, then B reads @4'h3 (memory wait=0) → mem_w_en is a single pulse with mem_w_addr=3 and mem_w_data=A5; a_ack 3 cycles after grant; b_rdata=A5 with b_ack; a_rdata unchanged.
- a_req and b_req held high continuously, acks dropping each req for one cycle → grants alternate A,B,A,B starting with A; never two consecutive grants to one client.
- Memory READ_WAIT=2: B reads → b_ack 5 cycles after grant; mem_r_en high exactly 1 cycle.
- Reset asserted during WAIT of A's write → no a_ack, strobes 0 next edge, state INIT, busy=1; after ready returns, pending b_req is serviced.
- MEM_ARBITER_TIMEOUT_EN defined, TIMEOUT=4, ready forced low after ISSUE → err=1 and a_ack pulse after 4 WAIT cycles; err stays 1 through later good transactions until reset.
